end_screen_ctrl: RTL and testbench
==================================

END_SCREEN_CTRL -- requirements
Module: end_screen_ctrl

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 120, frames end screen is shown before restart is accepted (min 1).
REQ-002 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (min 1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000, clocks button must be stable to change debounced level (min 1).
REQ-004 SHALL have one clock and a synchronous, active-high reset: i_clk input 1 (all logic on rising edge); i_rst input 1 (sync, active-high).
REQ-005 i_v_sync input 1, frame sync level, synchronous to i_clk; frame tick = registered rising edge.
REQ-006 i_game_over input 1, game-over request from game logic.
REQ-007 i_score input 12, live score from score compositor.
REQ-008 i_restart_btn input 1, raw asynchronous restart button, active-high.
REQ-009 o_is_end output 1, enables final-score overlay.
REQ-010 o_score_value output 12, score shown on overlay.
REQ-011 o_blink_on output 1, overlay blink phase, 1 = visible.
REQ-012 o_restart output 1, one-cycle game restart pulse.
REQ-013 o_hiscore output 12, best final score since reset.
REQ-014 o_state output 2, current FSM state encoding.

Function
REQ-015 SHALL implement FSM PLAY=0, FREEZE=1, SHOW=2, RESTART=3, driven on o_state.
REQ-016 PLAY: o_is_end=0; o_score_value <= i_score every cycle (1-cycle latency); i_game_over=1 -> FREEZE next cycle, o_score_value holds i_score sampled that cycle.
REQ-017 FREEZE: o_is_end=0, o_score_value frozen; on frame tick -> SHOW, frame counter and blink counter cleared, o_blink_on=1.
REQ-018 SHOW: o_is_end=1; frame counter increments per frame tick, saturating at HOLD_FRAMES.
REQ-019 SHOW: blink counter increments per frame tick; at BLINK_FRAMES-1 it wraps to 0 and o_blink_on toggles.
REQ-020 SHOW: debounced-button rising edge with frame counter == HOLD_FRAMES -> RESTART; edges before that are discarded (button must be released and re-pressed).
REQ-021 RESTART: o_restart=1 for exactly one cycle, o_is_end=0, o_score_value <= 0, o_blink_on <= 1; unconditional -> PLAY next cycle.
REQ-022 i_game_over SHALL be ignored outside PLAY; i_score ignored outside PLAY.
REQ-023 Button path: 2-flop synchronizer, then counter; debounced level changes only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-024 Frame tick and button edge in same cycle in SHOW: frame counter updates first is not required; transition uses counter value before the tick.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 i_rst=1 at any clock edge, including mid-SHOW, SHALL force: state PLAY, o_is_end=0, o_score_value=0, o_blink_on=1, o_restart=0, o_hiscore=0, all counters 0, synchronizer flops 0, debounced level 0, v_sync history 0.

Configuration
REQ-027 Macro END_SCREEN_HISCORE_EN defined: on FREEZE->SHOW, o_hiscore <= max(o_hiscore, o_score_value); o_hiscore never cleared except by reset.
REQ-028 Macro END_SCREEN_HISCORE_EN undefined: o_hiscore tied to 0, no comparator or register synthesized.

Verification (HOLD_FRAMES=4, BLINK_FRAMES=2, DEBOUNCE_CYCLES=3)
REQ-029 Reset, i_score=0x123, i_game_over pulse 1 cycle -> next cycle o_state=1, o_score_value=0x123 while i_score changes to 0x456.
REQ-030 From FREEZE, one v_sync rise -> o_state=2, o_is_end=1, o_blink_on=1; after 2 more frame ticks o_blink_on=0, after 4 total o_blink_on=1.
REQ-031 Press button (held 10 cycles) after 2 frames in SHOW -> no transition; release, 4th frame, re-press -> o_restart high exactly 1 cycle, o_state=0, o_score_value=0.
REQ-032 Button glitch high 2 cycles in SHOW after hold elapsed -> no restart; held 5 cycles -> restart.
REQ-033 With END_SCREEN_HISCORE_EN: games ending 0x100 then 0x080 -> o_hiscore=0x100 after both; without macro o_hiscore=0 throughout.
REQ-034 i_rst asserted 1 cycle mid-SHOW -> next cycle o_state=0, o_is_end=0, o_score_value=0, o_hiscore=0.

Source files
------------

// File: rtl/end_screen_ctrl_if.sv
// End-screen controller signal bundle.
// slave modport: the controller. master modport: the game side that drives
// the inputs and consumes the overlay/restart outputs.
interface end_screen_ctrl_if;
  logic        i_v_sync;
  logic        i_game_over;
  logic [11:0] i_score;
  logic        i_restart_btn;
  logic        o_is_end;
  logic [11:0] o_score_value;
  logic        o_blink_on;
  logic        o_restart;
  logic [11:0] o_hiscore;
  logic [1:0]  o_state;

  modport slave (
    input  i_v_sync, i_game_over, i_score, i_restart_btn,
    output o_is_end, o_score_value, o_blink_on, o_restart, o_hiscore, o_state
  );

  modport master (
    output i_v_sync, i_game_over, i_score, i_restart_btn,
    input  o_is_end, o_score_value, o_blink_on, o_restart, o_hiscore, o_state
  );
endinterface

// File: rtl/end_screen_ctrl.sv
// End-of-game screen controller: freezes the final score on game over,
// shows a blinking overlay for a minimum number of frames, then waits for a
// debounced restart press and emits a one-cycle restart pulse.
// Optional high-score tracking is enabled by defining END_SCREEN_HISCORE_EN;
// without it o_hiscore is constant zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// PLAY    | game running, overlay off, displayed score follows i_score
// FREEZE  | game over seen, score frozen, waiting for next frame tick
// SHOW    | overlay on and blinking, restart accepted after hold frames
// RESTART | one-cycle restart pulse, score cleared, back to PLAY
module end_screen_ctrl #(
  parameter int HOLD_FRAMES     = 120,
  parameter int BLINK_FRAMES    = 30,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  end_screen_ctrl_if.slave bus
);

  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [FW-1:0] FRAME_HOLD = FW'(HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [DW-1:0] DB_RELOAD  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    FREEZE  = 2'd1,
    SHOW    = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t        state;
  logic          is_end;
  logic [11:0]   score_value;
  logic          blink_on;
  logic          restart;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;

  logic          v_sync_q;
  logic          btn_meta;
  logic          btn_sync;
  logic          btn_db;
  logic          btn_db_q;
  logic [DW-1:0] db_cnt;

  logic          frame_tick;
  logic          btn_rise;

  assign frame_tick = bus.i_v_sync & ~v_sync_q;
  assign btn_rise   = btn_db & ~btn_db_q;

  // Frame-sync history, button synchronizer and debounce timer.
  // The timer is reloaded while the synchronized button agrees with the
  // debounced level, so the level flips only after DEBOUNCE_CYCLES
  // consecutive disagreeing cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_sync_q <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      v_sync_q <= bus.i_v_sync;
      btn_meta <= bus.i_restart_btn;
      btn_sync <= btn_meta;
      btn_db_q <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= DB_RELOAD;
      end else if (db_cnt == '0) begin
        btn_db <= btn_sync;
        db_cnt <= DB_RELOAD;
      end else begin
        db_cnt <= db_cnt - 1'b1;
      end
    end
  end

  // Main FSM with registered overlay outputs and frame/blink counters.
  // In SHOW a restart edge is judged against the frame count before any
  // same-cycle tick; early edges are simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= PLAY;
      is_end      <= 1'b0;
      score_value <= '0;
      blink_on    <= 1'b1;
      restart     <= 1'b0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
    end else begin
      restart <= 1'b0;
      case (state)
        PLAY: begin
          is_end      <= 1'b0;
          score_value <= bus.i_score;
          if (bus.i_game_over) state <= FREEZE;
        end
        FREEZE: begin
          if (frame_tick) begin
            state     <= SHOW;
            is_end    <= 1'b1;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
          end
        end
        SHOW: begin
          if (btn_rise && frame_cnt == FRAME_HOLD) begin
            state       <= RESTART;
            restart     <= 1'b1;
            is_end      <= 1'b0;
            score_value <= '0;
            blink_on    <= 1'b1;
          end else if (frame_tick) begin
            if (frame_cnt != FRAME_HOLD) frame_cnt <= frame_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        RESTART: begin
          state     <= PLAY;
          frame_cnt <= '0;
          blink_cnt <= '0;
        end
        default: state <= PLAY;
      endcase
    end
  end

`ifdef END_SCREEN_HISCORE_EN
  logic [11:0] hiscore;

  // Best final score, captured as the game leaves FREEZE for SHOW.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hiscore <= '0;
    end else if (state == FREEZE && frame_tick && score_value > hiscore) begin
      hiscore <= score_value;
    end
  end

  assign bus.o_hiscore = hiscore;
`else
  assign bus.o_hiscore = '0;
`endif

  assign bus.o_state       = state;
  assign bus.o_is_end      = is_end;
  assign bus.o_score_value = score_value;
  assign bus.o_blink_on    = blink_on;
  assign bus.o_restart     = restart;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Directed bench for end_screen_ctrl with HOLD_FRAMES=4, BLINK_FRAMES=2,
// DEBOUNCE_CYCLES=3. Inputs change 1 ns after a rising edge, outputs are
// sampled at the same point.
module tb_end_screen_ctrl;

`ifdef END_SCREEN_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  end_screen_ctrl_if bus ();

  end_screen_ctrl #(
    .HOLD_FRAMES    (4),
    .BLINK_FRAMES   (2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.i_v_sync = 1'b1;
    tick_clk();
    bus.i_v_sync = 1'b0;
    tick_clk();
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.i_v_sync      = 1'b0;
    bus.i_game_over   = 1'b0;
    bus.i_score       = 12'h000;
    bus.i_restart_btn = 1'b0;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic enter_show(input logic [11:0] score);
    bus.i_score     = score;
    bus.i_game_over = 1'b1;
    tick_clk();
    bus.i_game_over = 1'b0;
    frame();
  endtask

  // Holds the button for n_high cycles within an n_total cycle window and
  // records how many restart pulses appeared and the outputs at the pulse.
  task automatic press_watch(input int n_high, input int n_total,
                             output int pulses, output logic [1:0] st,
                             output logic [11:0] sv, output logic ie);
    pulses = 0;
    st     = 2'd0;
    sv     = 12'hFFF;
    ie     = 1'b1;
    for (int i = 0; i < n_total; i++) begin
      bus.i_restart_btn = (i < n_high);
      tick_clk();
      if (bus.o_restart === 1'b1) begin
        pulses++;
        st = bus.o_state;
        sv = bus.o_score_value;
        ie = bus.o_is_end;
      end
    end
    bus.i_restart_btn = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_score = 12'hABC;
    do_reset();
    checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.o_state); end
    checks++; if (bus.o_is_end !== 1'b0) begin failures++; $display("FAIL reset_is_end got=%0b exp=0", bus.o_is_end); end
    checks++; if (bus.o_score_value !== 12'h000) begin failures++; $display("FAIL reset_score got=%0h exp=0", bus.o_score_value); end
    checks++; if (bus.o_blink_on !== 1'b1) begin failures++; $display("FAIL reset_blink got=%0b exp=1", bus.o_blink_on); end
    checks++; if (bus.o_restart !== 1'b0) begin failures++; $display("FAIL reset_restart got=%0b exp=0", bus.o_restart); end
    checks++; if (bus.o_hiscore !== 12'h000) begin failures++; $display("FAIL reset_hiscore got=%0h exp=0", bus.o_hiscore); end
    bus.i_score = 12'h321;
    tick_clk();
    checks++; if (bus.o_score_value !== 12'h321) begin failures++; $display("FAIL play_follow got=%0h exp=321", bus.o_score_value); end
  endtask

  task automatic test_freeze();
    do_reset();
    bus.i_score     = 12'h123;
    bus.i_game_over = 1'b1;
    tick_clk();
    bus.i_game_over = 1'b0;
    bus.i_score     = 12'h456;
    checks++; if (bus.o_state !== 2'd1) begin failures++; $display("FAIL freeze_state got=%0d exp=1", bus.o_state); end
    checks++; if (bus.o_score_value !== 12'h123) begin failures++; $display("FAIL freeze_score got=%0h exp=123", bus.o_score_value); end
    bus.i_game_over = 1'b1;
    tick_clk();
    tick_clk();
    bus.i_game_over = 1'b0;
    checks++; if (bus.o_state !== 2'd1) begin failures++; $display("FAIL freeze_hold_state got=%0d exp=1", bus.o_state); end
    checks++; if (bus.o_score_value !== 12'h123) begin failures++; $display("FAIL freeze_hold_score got=%0h exp=123", bus.o_score_value); end
    checks++; if (bus.o_is_end !== 1'b0) begin failures++; $display("FAIL freeze_is_end got=%0b exp=0", bus.o_is_end); end
  endtask

  task automatic test_show_blink();
    bus.i_v_sync = 1'b1;
    tick_clk();
    checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL show_state got=%0d exp=2", bus.o_state); end
    checks++; if (bus.o_is_end !== 1'b1) begin failures++; $display("FAIL show_is_end got=%0b exp=1", bus.o_is_end); end
    checks++; if (bus.o_blink_on !== 1'b1) begin failures++; $display("FAIL show_blink0 got=%0b exp=1", bus.o_blink_on); end
    bus.i_v_sync = 1'b0;
    bus.i_score  = 12'h777;
    tick_clk();
    frame();
    checks++; if (bus.o_blink_on !== 1'b1) begin failures++; $display("FAIL blink_after1 got=%0b exp=1", bus.o_blink_on); end
    frame();
    checks++; if (bus.o_blink_on !== 1'b0) begin failures++; $display("FAIL blink_after2 got=%0b exp=0", bus.o_blink_on); end
    frame();
    frame();
    checks++; if (bus.o_blink_on !== 1'b1) begin failures++; $display("FAIL blink_after4 got=%0b exp=1", bus.o_blink_on); end
    checks++; if (bus.o_score_value !== 12'h123) begin failures++; $display("FAIL show_score_frozen got=%0h exp=123", bus.o_score_value); end
  endtask

  task automatic test_restart();
    int          p;
    logic [1:0]  st;
    logic [11:0] sv;
    logic        ie;
    do_reset();
    enter_show(12'h200);
    frame();
    frame();
    press_watch(10, 10, p, st, sv, ie);
    checks++; if (p !== 0) begin failures++; $display("FAIL early_press_pulses got=%0d exp=0", p); end
    checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL early_press_state got=%0d exp=2", bus.o_state); end
    press_watch(0, 8, p, st, sv, ie);
    checks++; if (p !== 0) begin failures++; $display("FAIL release_pulses got=%0d exp=0", p); end
    frame();
    frame();
    press_watch(6, 14, p, st, sv, ie);
    checks++; if (p !== 1) begin failures++; $display("FAIL repress_pulses got=%0d exp=1", p); end
    checks++; if (st !== 2'd3) begin failures++; $display("FAIL repress_pulse_state got=%0d exp=3", st); end
    checks++; if (sv !== 12'h000) begin failures++; $display("FAIL repress_score got=%0h exp=0", sv); end
    checks++; if (ie !== 1'b0) begin failures++; $display("FAIL repress_is_end got=%0b exp=0", ie); end
    checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL after_restart_state got=%0d exp=0", bus.o_state); end
  endtask

  task automatic test_glitch();
    int          p;
    logic [1:0]  st;
    logic [11:0] sv;
    logic        ie;
    do_reset();
    enter_show(12'h0AB);
    for (int i = 0; i < 4; i++) frame();
    press_watch(2, 10, p, st, sv, ie);
    checks++; if (p !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", p); end
    checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL glitch_state got=%0d exp=2", bus.o_state); end
    press_watch(5, 14, p, st, sv, ie);
    checks++; if (p !== 1) begin failures++; $display("FAIL held5_pulses got=%0d exp=1", p); end
    checks++; if (st !== 2'd3) begin failures++; $display("FAIL held5_state got=%0d exp=3", st); end
  endtask

  task automatic test_hiscore();
    int          p;
    logic [1:0]  st;
    logic [11:0] sv;
    logic        ie;
    do_reset();
    enter_show(12'h100);
    checks++; if (bus.o_hiscore !== (HI_EN ? 12'h100 : 12'h000)) begin failures++; $display("FAIL hiscore_game1 got=%0h exp=%0h", bus.o_hiscore, (HI_EN ? 12'h100 : 12'h000)); end
    for (int i = 0; i < 4; i++) frame();
    press_watch(5, 14, p, st, sv, ie);
    checks++; if (p !== 1) begin failures++; $display("FAIL hiscore_restart got=%0d exp=1", p); end
    enter_show(12'h080);
    checks++; if (bus.o_score_value !== 12'h080) begin failures++; $display("FAIL game2_score got=%0h exp=80", bus.o_score_value); end
    checks++; if (bus.o_hiscore !== (HI_EN ? 12'h100 : 12'h000)) begin failures++; $display("FAIL hiscore_game2 got=%0h exp=%0h", bus.o_hiscore, (HI_EN ? 12'h100 : 12'h000)); end
  endtask

  task automatic test_reset_mid_show();
    enter_show(12'h3C0);
    frame();
    checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL pre_reset_state got=%0d exp=2", bus.o_state); end
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.o_state); end
    checks++; if (bus.o_is_end !== 1'b0) begin failures++; $display("FAIL midrst_is_end got=%0b exp=0", bus.o_is_end); end
    checks++; if (bus.o_score_value !== 12'h000) begin failures++; $display("FAIL midrst_score got=%0h exp=0", bus.o_score_value); end
    checks++; if (bus.o_hiscore !== 12'h000) begin failures++; $display("FAIL midrst_hiscore got=%0h exp=0", bus.o_hiscore); end
    checks++; if (bus.o_blink_on !== 1'b1) begin failures++; $display("FAIL midrst_blink got=%0b exp=1", bus.o_blink_on); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_freeze();
    test_show_blink();
    test_restart();
    test_glitch();
    test_hiscore();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
